uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver, the receive end of the uart_loopback path (8N1, LSB first, idle high).

---
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- serial-to-parallel UART receiver (8N1, LSB first, idle-high line)
//
// Brings the asynchronous RXD pin into the clock domain through a two-flop
// synchroniser, detects the start-bit falling edge, samples every bit at its
// mid-point and checks the stop bit. A good byte is presented on rx_data
// together with a one-cycle rx_done strobe, so it can drive a UART
// transmitter's byte/trigger input directly.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> 8E1 frame: an even-parity bit follows data
//                                   bit 7 and parity_err reports mismatches.
//                      undefined -> 8N1 frame, parity_err tied to 0.
//
// Parameters:
//   CLOCK_FREQ   system clock frequency, Hz
//   BAUDRATE     line bit rate, bit/s
//   BIT_CYCLES   clocks per bit (CLOCK_FREQ/BAUDRATE), at most 65535
//   HALF_CYCLES  clocks from start edge to start-bit mid-point
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous active-high reset
//   serial_rxd  in   1  asynchronous UART line, idle 1
//   rx_data     out  8  last good byte, held until the next good frame
//   rx_done     out  1  one-cycle pulse: rx_data updated
//   frame_err   out  1  one-cycle pulse: stop bit sampled 0, byte dropped
//   parity_err  out  1  one-cycle pulse: parity mismatch, byte dropped
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int BAUDRATE    = 115200,
    parameter int BIT_CYCLES  = CLOCK_FREQ / BAUDRATE,
    parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [15:0] BIT_TERM  = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] HALF_TERM = 16'(HALF_CYCLES - 1);

    // Synchroniser (_p0, _p1) and edge-detect delay (_p2)
    logic        r_rxd_p0;
    logic        r_rxd_p1;
    logic        r_rxd_p2;

    logic [2:0]  r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_done;
    logic        r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic        r_par_bad;
    logic        r_parity_err;
`endif

    logic        w_fall;
    logic [15:0] w_term;
    logic        w_tick;

    // Flops preset to the idle level so reset release never fakes an edge
    // on an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_p0 <= 1'b1;
            r_rxd_p1 <= 1'b1;
            r_rxd_p2 <= 1'b1;
        end else begin
            r_rxd_p0 <= serial_rxd;
            r_rxd_p1 <= r_rxd_p0;
            r_rxd_p2 <= r_rxd_p1;
        end
    end

    // A held-low line (break) gives no edge, so IDLE never re-arms on it.
    assign w_fall = r_rxd_p2 & ~r_rxd_p1;

    // START waits only half a bit to land on the start-bit centre; every
    // later state waits a full bit, so all samples stay mid-bit.
    assign w_term = (r_state == S_START) ? HALF_TERM : BIT_TERM;
    assign w_tick = (r_baud == w_term);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_baud      <= 16'd0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // Every state change other than IDLE->START happens on a tick,
            // so clearing on tick (and holding 0 in IDLE) clears the counter
            // on every transition.
            if (r_state == S_IDLE || w_tick)
                r_baud <= 16'd0;
            else
                r_baud <= r_baud + 16'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_fall)
                        r_state <= S_START;
                end
                S_START: begin
                    if (w_tick) begin
                        if (!r_rxd_p1) begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift[r_idx] <= r_rxd_p1;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        // Even parity: data plus parity bit must have an
                        // even number of ones.
                        r_par_bad <= ^{r_shift, r_rxd_p1};
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        // Leaving at mid-stop leaves half a bit to catch the
                        // next start edge of a back-to-back frame.
                        r_state <= S_IDLE;
                        if (!r_rxd_p1) begin
                            r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            r_parity_err <= 1'b1;
`endif
                        end else begin
                            r_rx_data <= r_shift;
                            r_rx_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at default parameters.
// Frames are driven bit by bit; expected strobes go into a queue as frames
// are sent, a negedge monitor logs every strobe the DUT produces, and each
// test task pops and compares the two queues.
// Honours UART_RX_PARITY_EN (8E1 frames plus a parity-error test).
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT  = 434;
    localparam int HALF = 217;
`ifdef UART_RX_PARITY_EN
    localparam int NFRAME = 10;
`else
    localparam int NFRAME = 9;
`endif
    // Start edge to strobe: 2 sync + HALF + remaining bit periods + 1 register.
    localparam int LAT = 2 + HALF + NFRAME * BIT + 1;

    localparam int K_DONE = 1;
    localparam int K_FERR = 2;
    localparam int K_PERR = 3;
    localparam int K_MULTI = 7;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_rxd;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  m_ev;
    ev_t  ev_e;
    ev_t  ev_o;
    logic [7:0] last_good;
    int   t0;
    int   t1;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .serial_rxd (serial_rxd),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe logger: one entry per cycle with any strobe high.
    always @(negedge clk) begin
        if (rx_done || frame_err || parity_err) begin
            if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1)
                m_ev.kind = K_MULTI;
            else if (rx_done)
                m_ev.kind = K_DONE;
            else if (frame_err)
                m_ev.kind = K_FERR;
            else
                m_ev.kind = K_PERR;
            m_ev.data = rx_data;
            m_ev.cyc  = cyc;
            obs_q.push_back(m_ev);
        end
    end

    // Caller must be at posedge+#1; returns there, line left at stop_v.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic par_flip, output int start_cyc);
        serial_rxd = 1'b0;
        start_cyc  = cyc;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            serial_rxd = b[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        serial_rxd = (^b) ^ par_flip;
        repeat (BIT) @(posedge clk);
        #1;
`else
        if (par_flip) serial_rxd = 1'b1;
`endif
        serial_rxd = stop_v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int kind, input logic [7:0] data, input int c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        serial_rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int w;
        w = 0;
        while (obs_q.size() < n && w < budget) begin
            @(posedge clk);
            w++;
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        serial_rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        n_cmp++;
        if ({rx_done, frame_err, parity_err} !== 3'b000) begin
            n_err++; $display("FAIL reset_strobes: got %b want 000", {rx_done, frame_err, parity_err});
        end
        repeat (1000) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL reset_idle_events: got %0d want 0", obs_q.size());
        end
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_err++; $display("FAIL reset_idle_rx_data: got %h want 00", rx_data);
        end
        obs_q.delete();
        last_good = 8'h00;
    endtask

    task automatic test_single;
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        push_exp(K_DONE, 8'hA5, t0 + LAT);
        last_good = 8'hA5;
        wait_obs(1, 2 * BIT);
        while (exp_q.size() > 0) begin
            ev_e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL single_event: got none want kind %0d", ev_e.kind);
            end else begin
                ev_o = obs_q.pop_front();
                n_cmp += 2;
                if (ev_o.kind != ev_e.kind || ev_o.data !== ev_e.data) begin
                    n_err++; $display("FAIL single_value: got kind %0d data %h want kind %0d data %h",
                                      ev_o.kind, ev_o.data, ev_e.kind, ev_e.data);
                end
                if (ev_o.cyc < ev_e.cyc - 2 || ev_o.cyc > ev_e.cyc + 2) begin
                    n_err++; $display("FAIL single_latency: got %0d want %0d", ev_o.cyc - t0, LAT);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL single_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_glitch;
        serial_rxd = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        idle(2 * BIT);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL glitch_events: got %0d want 0", obs_q.size());
        end
        obs_q.delete();
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        push_exp(K_DONE, 8'h3C, t0 + LAT);
        last_good = 8'h3C;
        wait_obs(1, 2 * BIT);
        while (exp_q.size() > 0) begin
            ev_e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL glitch_next_event: got none want kind %0d", ev_e.kind);
            end else begin
                ev_o = obs_q.pop_front();
                n_cmp += 2;
                if (ev_o.kind != ev_e.kind || ev_o.data !== ev_e.data) begin
                    n_err++; $display("FAIL glitch_next_value: got kind %0d data %h want kind %0d data %h",
                                      ev_o.kind, ev_o.data, ev_e.kind, ev_e.data);
                end
                if (ev_o.cyc < ev_e.cyc - 2 || ev_o.cyc > ev_e.cyc + 2) begin
                    n_err++; $display("FAIL glitch_next_latency: got %0d want %0d", ev_o.cyc - t0, LAT);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL glitch_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_frame_err;
        send_frame(8'h5A, 1'b0, 1'b0, t0);
        push_exp(K_FERR, last_good, t0 + LAT);
        wait_obs(1, 2 * BIT);
        while (exp_q.size() > 0) begin
            ev_e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL ferr_event: got none want kind %0d", ev_e.kind);
            end else begin
                ev_o = obs_q.pop_front();
                n_cmp += 2;
                if (ev_o.kind != ev_e.kind || ev_o.data !== ev_e.data) begin
                    n_err++; $display("FAIL ferr_value: got kind %0d data %h want kind %0d data %h",
                                      ev_o.kind, ev_o.data, ev_e.kind, ev_e.data);
                end
                if (ev_o.cyc < ev_e.cyc - 2 || ev_o.cyc > ev_e.cyc + 2) begin
                    n_err++; $display("FAIL ferr_latency: got %0d want %0d", ev_o.cyc - t0, LAT);
                end
            end
        end
        // Line stays low (break) for 5 more bit times: must not re-arm.
        serial_rxd = 1'b0;
        repeat (5 * BIT) @(posedge clk);
        #1;
        idle(2 * BIT);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL ferr_break_events: got %0d want 0", obs_q.size());
        end
        n_cmp++;
        if (rx_data !== last_good) begin
            n_err++; $display("FAIL ferr_rx_data: got %h want %h", rx_data, last_good);
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        send_frame(8'h00, 1'b1, 1'b0, t0);
        send_frame(8'hFF, 1'b1, 1'b0, t1);
        push_exp(K_DONE, 8'h00, t0 + LAT);
        push_exp(K_DONE, 8'hFF, t1 + LAT);
        last_good = 8'hFF;
        wait_obs(2, 2 * BIT);
        while (exp_q.size() > 0) begin
            ev_e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL b2b_event: got none want data %h", ev_e.data);
            end else begin
                ev_o = obs_q.pop_front();
                n_cmp += 2;
                if (ev_o.kind != ev_e.kind || ev_o.data !== ev_e.data) begin
                    n_err++; $display("FAIL b2b_value: got kind %0d data %h want kind %0d data %h",
                                      ev_o.kind, ev_o.data, ev_e.kind, ev_e.data);
                end
                if (ev_o.cyc < ev_e.cyc - 2 || ev_o.cyc > ev_e.cyc + 2) begin
                    n_err++; $display("FAIL b2b_latency: got cycle %0d want %0d", ev_o.cyc, ev_e.cyc);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL b2b_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_mid_reset;
        fork
            send_frame(8'h81, 1'b1, 1'b0, t0);
            begin
                // Middle of data bit 4 (sixth bit period of the frame).
                repeat (5 * BIT + HALF) @(posedge clk);
                #1;
                rst = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        last_good = 8'h00;
        idle(BIT);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL rst_mid_events: got %0d want 0", obs_q.size());
        end
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_err++; $display("FAIL rst_mid_rx_data: got %h want 00", rx_data);
        end
        obs_q.delete();
        send_frame(8'h7E, 1'b1, 1'b0, t0);
        push_exp(K_DONE, 8'h7E, t0 + LAT);
        last_good = 8'h7E;
        wait_obs(1, 2 * BIT);
        while (exp_q.size() > 0) begin
            ev_e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL rst_next_event: got none want kind %0d", ev_e.kind);
            end else begin
                ev_o = obs_q.pop_front();
                n_cmp += 2;
                if (ev_o.kind != ev_e.kind || ev_o.data !== ev_e.data) begin
                    n_err++; $display("FAIL rst_next_value: got kind %0d data %h want kind %0d data %h",
                                      ev_o.kind, ev_o.data, ev_e.kind, ev_e.data);
                end
                if (ev_o.cyc < ev_e.cyc - 2 || ev_o.cyc > ev_e.cyc + 2) begin
                    n_err++; $display("FAIL rst_next_latency: got %0d want %0d", ev_o.cyc - t0, LAT);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL rst_next_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        // 8'h01 has odd weight, so even parity needs 1; sending 0 is a mismatch.
        send_frame(8'h01, 1'b1, 1'b1, t0);
        push_exp(K_PERR, last_good, t0 + LAT);
        wait_obs(1, 2 * BIT);
        while (exp_q.size() > 0) begin
            ev_e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL parity_event: got none want kind %0d", ev_e.kind);
            end else begin
                ev_o = obs_q.pop_front();
                n_cmp += 2;
                if (ev_o.kind != ev_e.kind || ev_o.data !== ev_e.data) begin
                    n_err++; $display("FAIL parity_value: got kind %0d data %h want kind %0d data %h",
                                      ev_o.kind, ev_o.data, ev_e.kind, ev_e.data);
                end
                if (ev_o.cyc < ev_e.cyc - 2 || ev_o.cyc > ev_e.cyc + 2) begin
                    n_err++; $display("FAIL parity_latency: got %0d want %0d", ev_o.cyc - t0, LAT);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL parity_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask
`endif

    initial begin
        rst = 1'b1;
        serial_rxd = 1'b1;
        last_good = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_mid_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
